// File: rtl/cur_dec_pkg.sv
// Shared widths and decode functions for the current-steering DAC cell decoder.
// The decode functions are also used by the top to derive the reset pattern.
package cur_dec_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CELLS  = 16;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [CELLS-1:0]  cells_t;

  // Unary pattern: the lowest `code` cells are on, so out[15] is never set
  function automatic cells_t thermo_f(input code_t code);
    return (CELLS'(1) << code) - CELLS'(1);
  endfunction

  // Exactly one cell on, at position `code`
  function automatic cells_t onehot_f(input code_t code);
    return CELLS'(1) << code;
  endfunction

  function automatic cells_t decode_f(input bit thermo, input code_t code);
    return thermo ? thermo_f(code) : onehot_f(code);
  endfunction

endpackage

// File: rtl/cur_dec_comb.sv
// Combinational 4-to-16 decoder; the decode style is fixed at elaboration.
module cur_dec_comb
  import cur_dec_pkg::*;
#(
  parameter bit THERMO = 1'b1
) (
  input  logic [CODE_W-1:0] code,
  output logic [CELLS-1:0]  out_c
);

  generate
    if (THERMO) begin : g_thermo
      assign out_c = thermo_f(code);
    end else begin : g_onehot
      assign out_c = onehot_f(code);
    end
  endgenerate

endmodule

// File: rtl/cur_dec_sync.sv
// Registered DAC cell-enable decoder: code and decoded cells load together on
// an en-qualified edge so every cell switch toggles on the same clock edge.
module cur_dec_sync
  import cur_dec_pkg::*;
#(
  parameter bit                 THERMO   = 1'b1,
  parameter logic [CODE_W-1:0]  RST_CODE = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] in,
  output logic [CELLS-1:0]  out,
  output logic [CODE_W-1:0] code_q
);

  localparam cells_t RST_OUT = decode_f(THERMO, RST_CODE);

  logic [CELLS-1:0] dec_c;

  // Decoding the incoming code keeps out and code_q in lockstep on one edge
  cur_dec_comb #(
    .THERMO (THERMO)
  ) u_comb (
    .code  (in),
    .out_c (dec_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= RST_CODE;
      out    <= RST_OUT;
    end else if (en) begin
      code_q <= in;
      out    <= dec_c;
    end
  end

endmodule

// File: tb/tb_cur_dec_sync.sv
// Directed bench for cur_dec_sync: thermometer, one-hot and non-default reset
// instances share stimulus and are checked against hand-written patterns.
module tb_cur_dec_sync;

  typedef struct {
    logic        en;
    logic [3:0]  din;
    logic [3:0]  exp_code;
    logic [15:0] exp_th;
    logic [15:0] exp_oh;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [3:0]  din = 4'h0;
  logic [15:0] out_th, out_oh, out_r8;
  logic [3:0]  code_th, code_oh, code_r8;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [15:0] th_tab [16] = '{16'h0000, 16'h0001, 16'h0003, 16'h0007,
                               16'h000F, 16'h001F, 16'h003F, 16'h007F,
                               16'h00FF, 16'h01FF, 16'h03FF, 16'h07FF,
                               16'h0FFF, 16'h1FFF, 16'h3FFF, 16'h7FFF};
  logic [15:0] oh_tab [16] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                               16'h0010, 16'h0020, 16'h0040, 16'h0080,
                               16'h0100, 16'h0200, 16'h0400, 16'h0800,
                               16'h1000, 16'h2000, 16'h4000, 16'h8000};

  vec_t vecs[$];

  always #5 clk = ~clk;

  cur_dec_sync #(.THERMO(1'b1), .RST_CODE(4'd0)) u_th (
    .clk(clk), .rst(rst), .en(en), .in(din), .out(out_th), .code_q(code_th));
  cur_dec_sync #(.THERMO(1'b0), .RST_CODE(4'd0)) u_oh (
    .clk(clk), .rst(rst), .en(en), .in(din), .out(out_oh), .code_q(code_oh));
  cur_dec_sync #(.THERMO(1'b1), .RST_CODE(4'd8)) u_r8 (
    .clk(clk), .rst(rst), .en(en), .in(din), .out(out_r8), .code_q(code_r8));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] c_th, input logic [15:0] o_th,
                           input logic [3:0] c_oh, input logic [15:0] o_oh,
                           input logic [3:0] c_r8, input logic [15:0] o_r8);
    check({name, " th.code"}, 16'(code_th), 16'(c_th));
    check({name, " th.out"},  out_th, o_th);
    check({name, " oh.code"}, 16'(code_oh), 16'(c_oh));
    check({name, " oh.out"},  out_oh, o_oh);
    check({name, " r8.code"}, 16'(code_r8), 16'(c_r8));
    check({name, " r8.out"},  out_r8, o_r8);
  endtask

  initial begin
    // Vector table: full sweep, then a hold with a different code on the input
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 4'(i), 4'(i), th_tab[i], oh_tab[i], $sformatf("sweep%0d", i)});
    vecs.push_back('{1'b1, 4'd7, 4'd7, 16'h007F, 16'h0080, "load7"});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 4'd12, 4'd7, 16'h007F, 16'h0080, $sformatf("hold%0d", i)});

    // Async reset with no clock edge yet
    din = 4'hA;
    #1 rst = 1'b1;
    #1 check_all("rst_noclk", 4'd0, 16'h0000, 4'd0, 16'h0001, 4'd8, 16'h00FF);

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all("rel_noen", 4'd0, 16'h0000, 4'd0, 16'h0001, 4'd8, 16'h00FF);

    foreach (vecs[i]) begin
      @(negedge clk);
      en  = vecs[i].en;
      din = vecs[i].din;
      @(posedge clk);
      #1;
      check_all(vecs[i].name, vecs[i].exp_code, vecs[i].exp_th,
                vecs[i].exp_code, vecs[i].exp_oh, vecs[i].exp_code, vecs[i].exp_th);
      check({vecs[i].name, " popcnt"}, 16'($countones(out_th)), 16'(vecs[i].exp_code));
      check({vecs[i].name, " onehot"}, 16'($countones(out_oh)), 16'd1);
    end

    // Mid-operation async reset between edges, with a pending en
    @(negedge clk);
    en = 1'b1; din = 4'd15;
    @(posedge clk);
    #1 check_all("pre_rst", 4'd15, 16'h7FFF, 4'd15, 16'h8000, 4'd15, 16'h7FFF);
    #2 rst = 1'b1; din = 4'd9;
    #1 check_all("mid_rst", 4'd0, 16'h0000, 4'd0, 16'h0001, 4'd8, 16'h00FF);
    @(posedge clk);
    #1 check_all("rst_over_en", 4'd0, 16'h0000, 4'd0, 16'h0001, 4'd8, 16'h00FF);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; din = 4'd3;
    @(posedge clk);
    #1 check_all("post_rst3", 4'd3, 16'h0007, 4'd3, 16'h0008, 4'd3, 16'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
